// File: rtl/i2s_rx.sv
`default_nettype none
// i2s_rx: oversampled I2S slave receiver delivering stereo pairs over valid/ready. Rev 1.0.
// Optional I2S_RX_OVERRUN_EN: drop pairs under backpressure and set sticky overrun.
module i2s_rx #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sck,
  input  logic             lrck,
  input  logic             sdin,
  output logic [WIDTH-1:0] left_data,
  output logic [WIDTH-1:0] right_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             frame_err
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  logic [1:0]       sck_sync_q, lrck_sync_q, sdin_sync_q;
  logic             sck_d_q, lrck_prev_q, synced_q, have_left_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] shift_q, left_hold_q, left_data_q, right_data_q;
  logic             out_valid_q, frame_err_q;

  logic             sck_s, lrck_s, sdin_s, tick, change_tick;
  logic [WIDTH-1:0] shift_d;
  logic             word_done, short_err, pair_formed, pair_load;

  assign sck_s       = sck_sync_q[1];
  assign lrck_s      = lrck_sync_q[1];
  assign sdin_s      = sdin_sync_q[1];
  assign tick        = sck_s & ~sck_d_q;
  assign change_tick = tick & (lrck_s != lrck_prev_q);

  // On normal ticks lrck_prev_q equals lrck_s, so it names the channel in both cases.
  always_comb begin
    shift_d   = {shift_q[WIDTH-2:0], sdin_s};
    word_done = 1'b0;
    short_err = 1'b0;
    if (tick && synced_q) begin
      if (cnt_q == C_LAST) begin
        word_done = 1'b1;
      end else if (change_tick && (cnt_q < C_LAST)) begin
        short_err = 1'b1;
      end
    end
  end

  assign pair_formed = word_done & lrck_prev_q & have_left_q;

`ifdef I2S_RX_OVERRUN_EN
  logic overrun_q;
  assign pair_load = pair_formed & (~out_valid_q | out_ready);
  assign overrun   = overrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (pair_formed && out_valid_q && !out_ready) begin
      overrun_q <= 1'b1;
    end
  end
`else
  assign pair_load = pair_formed;
  assign overrun   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q   <= '0;
      lrck_sync_q  <= '0;
      sdin_sync_q  <= '0;
      sck_d_q      <= 1'b0;
      lrck_prev_q  <= 1'b0;
      synced_q     <= 1'b0;
      have_left_q  <= 1'b0;
      cnt_q        <= '0;
      shift_q      <= '0;
      left_hold_q  <= '0;
      left_data_q  <= '0;
      right_data_q <= '0;
      out_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[0], sck};
      lrck_sync_q <= {lrck_sync_q[0], lrck};
      sdin_sync_q <= {sdin_sync_q[0], sdin};
      sck_d_q     <= sck_s;
      frame_err_q <= short_err;

      if (tick) begin
        lrck_prev_q <= lrck_s;
        if (change_tick) begin
          synced_q <= 1'b1;
          cnt_q    <= '0;
          // The change tick carries the closing word's LSB only for exact-width slots.
          if (cnt_q == C_LAST) begin
            shift_q <= shift_d;
          end
        end else if (cnt_q < C_FULL) begin
          shift_q <= shift_d;
          cnt_q   <= cnt_q + C_ONE;
        end
      end

      if (word_done && !lrck_prev_q) begin
        left_hold_q <= shift_d;
        have_left_q <= 1'b1;
      end else if ((word_done && lrck_prev_q) || (short_err && !lrck_prev_q)) begin
        have_left_q <= 1'b0;
      end

      if (pair_load) begin
        left_data_q  <= left_hold_q;
        right_data_q <= shift_d;
        out_valid_q  <= 1'b1;
      end else if (out_ready) begin
        out_valid_q  <= 1'b0;
      end
    end
  end

  assign left_data  = left_data_q;
  assign right_data = right_data_q;
  assign out_valid  = out_valid_q;
  assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx.sv
`default_nettype none
// tb_i2s_rx: scoreboard bench for i2s_rx (WIDTH=16, sck = clk/8) with a slot-level reference model.
module tb_i2s_rx;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sck = 1'b0;
  logic         lrck = 1'b0;
  logic         sdin = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] left_data, right_data;
  logic         out_valid, overrun, frame_err;

  i2s_rx #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .sck(sck), .lrck(lrck), .sdin(sdin),
    .left_data(left_data), .right_data(right_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] l;
    logic [W-1:0] r;
  } pair_t;

  pair_t        exp_q[$];
  int           total = 0;
  int           bad = 0;
  int           fe_seen = 0;
  int           fe_exp = 0;
  bit           exp_ovr = 1'b0;
  bit           rdy_rand = 1'b0;
  bit           hold_mode = 1'b0;
  bit           m_pending = 1'b0;
  bit           lat_arm = 1'b0;
  int           lat_cnt = 0;

  bit           s_lr[$];
  int           s_len[$];
  logic [W-1:0] s_word[$];
  logic [1:0]   s_pad[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic add_slot(input bit lr, input int len, input logic [W-1:0] word, input logic [1:0] pad);
    s_lr.push_back(lr);
    s_len.push_back(len);
    s_word.push_back(word);
    s_pad.push_back(pad);
  endtask

  task automatic clear_slots();
    s_lr.delete();
    s_len.delete();
    s_word.delete();
    s_pad.delete();
  endtask

  task automatic push_pair(input logic [W-1:0] l, input logic [W-1:0] r);
    pair_t p;
    p.l = l;
    p.r = r;
    if (hold_mode && m_pending) begin
`ifdef I2S_RX_OVERRUN_EN
      exp_ovr = 1'b1;
`else
      void'(exp_q.pop_back());
      exp_q.push_back(p);
`endif
    end else begin
      exp_q.push_back(p);
      m_pending = 1'b1;
    end
  endtask

  // A slot is seen once an lrck change has occurred at or before its start; it closes
  // when the next slot begins. Slots of at least W bits yield their top W bits.
  task automatic model();
    bit           prev = 1'b0;
    bit           syn = 1'b0;
    bit           have = 1'b0;
    logic [W-1:0] hold = '0;
    int           n = s_lr.size();
    m_pending = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (s_lr[i] != prev) syn = 1'b1;
      prev = s_lr[i];
      if (syn && (i + 1 < n)) begin
        if (s_len[i] >= W) begin
          if (!s_lr[i]) begin
            hold = s_word[i];
            have = 1'b1;
          end else begin
            if (have) push_pair(hold, s_word[i]);
            have = 1'b0;
          end
        end else begin
          fe_exp++;
          if (!s_lr[i]) have = 1'b0;
        end
      end
    end
  endtask

  // Data trails lrck by one sck period, so each slot's last bit rides the next slot's first cycle.
  task automatic play(input int arm_k);
    bit lr_s[$];
    bit b_s[$];
    bit b;
    for (int i = 0; i < s_lr.size(); i++) begin
      for (int j = 0; j < s_len[i]; j++) begin
        if (j < W) b = s_word[i][W-1-j];
        else if (s_pad[i] == 2'd1) b = 1'b1;
        else if (s_pad[i] == 2'd2) b = 1'($urandom_range(0, 1));
        else b = 1'b0;
        lr_s.push_back(s_lr[i]);
        b_s.push_back(b);
      end
    end
    for (int k = 0; k < lr_s.size(); k++) begin
      sck  = 1'b0;
      lrck = lr_s[k];
      sdin = (k == 0) ? 1'b0 : b_s[k-1];
      repeat (4) step();
      sck = 1'b1;
      if (k == arm_k) begin
        lat_cnt = 0;
        lat_arm = 1'b1;
      end
      repeat (4) step();
    end
    sck = 1'b0;
    repeat (4) step();
  endtask

  task automatic scenario(input string name, input bit do_rst, input bit hold, input bit rrand, input int arm_k);
    out_ready = hold ? 1'b0 : 1'b1;
    if (do_rst) begin
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
    end
    fe_seen   = 0;
    fe_exp    = 0;
    exp_ovr   = 1'b0;
    hold_mode = hold;
    exp_q.delete();
    model();
    rdy_rand = rrand;
    play(arm_k);
    rdy_rand = 1'b0;
    repeat (10) step();
    if (hold) begin
      chk({name, ":held_valid"}, out_valid, 1);
      if (exp_q.size() > 0) begin
        chk({name, ":held_left"}, left_data, exp_q[0].l);
        chk({name, ":held_right"}, right_data, exp_q[0].r);
      end
      chk({name, ":overrun"}, overrun, exp_ovr);
    end
    out_ready = 1'b1;
    repeat (30) step();
    chk({name, ":frame_err_count"}, fe_seen, fe_exp);
    chk({name, ":pairs_outstanding"}, exp_q.size(), 0);
    chk({name, ":overrun_final"}, overrun, exp_ovr);
    clear_slots();
  endtask

  always @(posedge clk) if (lat_arm) lat_cnt++;

  initial begin : monitor
    bit    pv = 1'b0;
    bit    pfe = 1'b0;
    pair_t e;
    forever begin
      @(negedge clk);
      if (frame_err) begin
        fe_seen++;
        chk("frame_err_one_clk", pfe, 0);
      end
      if (out_valid && !pv && lat_arm) begin
        chk("valid_latency_clk", lat_cnt, 3);
        lat_arm = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pair: got %0h/%0h expected none", left_data, right_data);
        end else begin
          e = exp_q.pop_front();
          chk("left_data", left_data, e.l);
          chk("right_data", right_data, e.r);
        end
      end
      pv  = out_valid;
      pfe = frame_err;
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit lr;
    int n, r, len;
    repeat (3) step();
    chk("reset:left_data", left_data, 0);
    chk("reset:right_data", right_data, 0);
    chk("reset:out_valid", out_valid, 0);
    chk("reset:overrun", overrun, 0);
    chk("reset:frame_err", frame_err, 0);

    // Exact 16-bit slots; latency measured from the sck edge carrying the right LSB.
    add_slot(0, 3, '0, 0);
    add_slot(1, 16, 16'h5555, 0);
    add_slot(0, 16, 16'hA5C3, 0);
    add_slot(1, 16, 16'h1234, 0);
    add_slot(0, 2, '0, 0);
    scenario("basic", 1, 0, 0, 3 + 16 + 16 + 16);

    add_slot(0, 3, '0, 0);
    add_slot(1, 32, 16'h0F0F, 1);
    add_slot(0, 32, 16'h8001, 1);
    add_slot(1, 32, 16'h7FFE, 1);
    add_slot(0, 2, '0, 0);
    scenario("slot32", 1, 0, 0, -1);

    add_slot(0, 3, '0, 0);
    add_slot(1, 16, 16'h0001, 0);
    add_slot(0, 10, 16'hFFFF, 0);
    add_slot(1, 16, 16'h9999, 0);
    add_slot(0, 16, 16'hC001, 0);
    add_slot(1, 16, 16'hD00D, 0);
    add_slot(0, 2, '0, 0);
    scenario("short_left", 1, 0, 0, -1);

    add_slot(0, 3, '0, 0);
    add_slot(1, 16, 16'h0000, 0);
    add_slot(0, 16, 16'h1111, 0);
    add_slot(1, 16, 16'h2222, 0);
    add_slot(0, 16, 16'h3333, 0);
    add_slot(1, 16, 16'h4444, 0);
    add_slot(0, 2, '0, 0);
    scenario("backpressure", 1, 1, 0, -1);

    add_slot(1, 7, 16'hFFFF, 2);
    add_slot(0, 16, 16'h6789, 0);
    add_slot(1, 16, 16'hABCD, 0);
    add_slot(0, 2, '0, 0);
    scenario("mid_right", 1, 0, 0, -1);

    // Stream ends 8 bits into a left word, then a one-clk reset lands there.
    add_slot(0, 3, '0, 0);
    add_slot(1, 16, 16'h2468, 0);
    add_slot(0, 16, 16'hBEEF, 0);
    add_slot(1, 16, 16'hCAFE, 0);
    add_slot(0, 8, 16'hDEAD, 0);
    scenario("pre_reset", 1, 0, 0, -1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midreset:left_data", left_data, 0);
    chk("midreset:right_data", right_data, 0);
    chk("midreset:out_valid", out_valid, 0);
    chk("midreset:frame_err", frame_err, 0);
    add_slot(0, 8, 16'hAD00, 0);
    add_slot(1, 16, 16'h1357, 0);
    add_slot(0, 16, 16'h0F0F, 0);
    add_slot(1, 16, 16'hF0F0, 0);
    add_slot(0, 2, '0, 0);
    scenario("post_reset", 0, 0, 0, -1);

    for (int t = 0; t < 6; t++) begin
      lr = 1'($urandom_range(0, 1));
      add_slot(lr, $urandom_range(1, 20), W'($urandom), 2);
      n = $urandom_range(6, 9);
      for (int s = 0; s < n; s++) begin
        lr = ~lr;
        r = $urandom_range(0, 9);
        if (r < 4) len = 16;
        else if (r < 8) len = $urandom_range(17, 32);
        else len = $urandom_range(4, 15);
        add_slot(lr, len, W'($urandom), 2);
      end
      add_slot(~lr, 2, '0, 0);
      scenario("random", 1, 0, 1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
